matvec_mac_engine: RTL

//  Parametrised signed matrix-vector multiply engine: y[ROWS] = A[ROWS][COLS] * x[COLS].

---
 rtl/matvec_mac_engine.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/matvec_mac_engine.sv
// Signed matrix-vector multiply engine: y[ROWS] = A[ROWS][COLS] * x[COLS], one column per cycle.
// Optional feature macro SATURATE_EN: clamp accumulators and report the sticky sat flag.
module matvec_mac_engine #(
   parameter int ROWS   = 8,
   parameter int COLS   = 8,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   localparam int SEL_W = $clog2(ROWS + 1),
   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [SEL_W-1:0]         wr_sel,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     start,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     sat,
   input  logic [IDX_W-1:0]         rd_idx,
   output logic signed [ACC_W-1:0]  rd_data
);

   localparam int PTR_W  = $clog2(COLS + 1);
   localparam int K_W    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    state;
   logic [K_W-1:0]            k;
   logic signed [DATA_W-1:0]  a_mem [ROWS][COLS];
   logic signed [DATA_W-1:0]  x_mem [COLS];
   logic [PTR_W-1:0]          wptr  [ROWS+1];
   logic signed [ACC_W-1:0]   acc   [ROWS];
   logic signed [ACC_W-1:0]   acc_next [ROWS];
   logic [ROWS-1:0]           clamp;
   logic                      all_full;
   logic                      sel_full;
   logic                      wr_ok;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      all_full = 1'b1;
      for (int i = 0; i <= ROWS; i++) begin
         if (wptr[i] != PTR_W'(COLS)) all_full = 1'b0;
      end
      sel_full = 1'b1;
      if (wr_sel <= SEL_W'(ROWS)) sel_full = (wptr[wr_sel] == PTR_W'(COLS));
   end

   assign wr_ok = wr_en && (state == S_IDLE) && !sel_full;
   assign ready = (state == S_IDLE) && all_full;
   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);

   // One MAC per row: the k==0 term restarts the sum so a new job needs no explicit clear.
   always_comb begin
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W-1:0]  base;
      logic signed [ACC_W:0]    sum;
      for (int r = 0; r < ROWS; r++) begin
         prod        = a_mem[r][k] * x_mem[k];
         base        = (k == '0) ? '0 : acc[r];
         sum         = {base[ACC_W-1], base}
                     + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
         acc_next[r] = sum[ACC_W-1:0];
         clamp[r]    = 1'b0;
`ifdef SATURATE_EN
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            clamp[r]    = 1'b1;
            acc_next[r] = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
`endif
      end
   end

   // NOTE: buffer storage carries no reset; a buffer is only read after its pointer shows it full.
   always_ff @(posedge clk) begin
      if (rst_n && !clr && wr_ok) begin
         if (wr_sel == SEL_W'(ROWS)) x_mem[wptr[wr_sel][K_W-1:0]] <= wr_data;
         else a_mem[wr_sel[IDX_W-1:0]][wptr[wr_sel][K_W-1:0]] <= wr_data;
      end
   end

`ifdef SATURATE_EN
   logic sat_q;
   assign sat = sat_q;
`else
   assign sat = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         state <= S_IDLE;
         k     <= '0;
         err   <= 1'b0;
`ifdef SATURATE_EN
         sat_q <= 1'b0;
`endif
         for (int i = 0; i <= ROWS; i++) wptr[i] <= '0;
         for (int r = 0; r < ROWS; r++) acc[r] <= '0;
      end else begin
         if (wr_en && !wr_ok) err <= 1'b1;
         if (wr_ok) wptr[wr_sel] <= wptr[wr_sel] + 1'b1;
         case (state)
            S_IDLE: begin
               if (start && ready) begin
                  state <= S_RUN;
                  k     <= '0;
               end
            end
            S_RUN: begin
               for (int r = 0; r < ROWS; r++) acc[r] <= acc_next[r];
`ifdef SATURATE_EN
               if (|clamp) sat_q <= 1'b1;
`endif
               if (k == K_W'(COLS - 1)) state <= S_DONE;
               else k <= k + 1'b1;
            end
            S_DONE: begin
               // Buffers are consumed: the next job must reload every buffer.
               for (int i = 0; i <= ROWS; i++) wptr[i] <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_idx < IDX_W'(ROWS) || ROWS == (1 << IDX_W)) rd_data = acc[rd_idx];
   end

endmodule
